ps2_key_events: RTL and testbench

Parametrised PS/2 keyboard front end: receives raw PS/2 frames, decodes make/break (and optionally E0-extended) scan-code sequences, suppresses typematic repeats, and delivers press/release events through a valid/ready event FIFO. Also keeps a held-key bitmap of game control keys for direct use by the tank controller. Sits between the board PS/2 pins and game logic, on the 100 MHz system clock.

---
 rtl/ps2_key_events.sv | 253 +++++++++++++++++++++++++
 tb/tb_ps2_key_events.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_events.sv
// rtl/ps2_key_events.sv - PS/2 keyboard front end: frame receiver, make/break decoder, held-key map, event FIFO.
// Optional E0-extended key support is enabled by defining PS2_EXTENDED_KEYS_EN.
module ps2_key_events #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_press,
  output logic       ev_ext,
  output logic [7:0] ev_code,
  output logic [7:0] ev_ascii,
  output logic [7:0] held,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [7:0] ascii_of(input logic ext, input logic [7:0] code);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
        8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
        8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
        8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
        8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
        8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
        8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
        8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
        8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
        8'h3E: a = 8'h38; 8'h46: a = 8'h39;
        8'h29: a = 8'h20; 8'h66: a = 8'h08; 8'h5A: a = 8'h0D;
        default: a = 8'h00;
      endcase
    end
`ifdef PS2_EXTENDED_KEYS_EN
    else begin
      case (code)
        8'h75: a = 8'h80; 8'h72: a = 8'h81; 8'h6B: a = 8'h82; 8'h74: a = 8'h83;
        default: a = 8'h00;
      endcase
    end
`endif
    return a;
  endfunction

  function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    case ({ext, code})
      9'h01D: m = 8'h01; 9'h01C: m = 8'h02; 9'h01B: m = 8'h04; 9'h023: m = 8'h08;
`ifdef PS2_EXTENDED_KEYS_EN
      9'h175: m = 8'h10; 9'h172: m = 8'h20; 9'h16B: m = 8'h40; 9'h174: m = 8'h80;
`endif
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Pin synchronisers and ps2_clk glitch filter
  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic clk_filt, fall, fall_bit;
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      {clk_s1, clk_s2, dat_s1, dat_s2} <= 4'b1111;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      fall_bit <= 1'b1;
    end else begin
      {clk_s2, clk_s1} <= {clk_s1, ps2_clk};
      {dat_s2, dat_s1} <= {dat_s1, ps2_data};
      fall <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        fall     <= ~clk_s2;
        fall_bit <= dat_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame receiver; shreg collects 8 data bits then parity, LSB first
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [TW-1:0] idle_cnt;
  logic          byte_stb;
  logic [7:0]    rx_byte;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      byte_stb  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (fall_bit) frame_err <= 1'b1;
          else          bit_cnt   <= 4'd1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt   <= '0;
          rx_byte   <= shreg[7:0];
          byte_stb  <= fall_bit & (^shreg);
          frame_err <= ~(fall_bit & (^shreg));
        end else begin
          shreg   <= {fall_bit, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // Scan-code decoder
`ifdef PS2_EXTENDED_KEYS_EN
  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_BREAK} state_t;
`endif
  state_t state_q, state_d;
  logic   is_make, is_break, ext_c, emit_d, emit_q;
  logic   last_valid;
  logic [8:0]  last_key;
  logic [17:0] emit_entry;

  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    ext_c    = 1'b0;
    if (byte_stb) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte == 8'hF0) state_d = S_BREAK;
`ifdef PS2_EXTENDED_KEYS_EN
          else if (rx_byte == 8'hE0) state_d = S_EXT;
`else
          else if (rx_byte == 8'hE0) state_d = S_IDLE;
`endif
          else if (rx_byte inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) state_d = S_IDLE;
          else is_make = 1'b1;
        end
        S_BREAK: begin
          is_break = 1'b1;
          state_d  = S_IDLE;
        end
`ifdef PS2_EXTENDED_KEYS_EN
        S_EXT: begin
          if (rx_byte == 8'hF0) begin
            state_d = S_EXT_BREAK;
          end else begin
            is_make = 1'b1;
            ext_c   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BREAK: begin
          is_break = 1'b1;
          ext_c    = 1'b1;
          state_d  = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    emit_d = is_break || (is_make && !(last_valid && last_key == {ext_c, rx_byte}));
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q    <= S_IDLE;
      emit_q     <= 1'b0;
      emit_entry <= '0;
      last_valid <= 1'b0;
      last_key   <= '0;
      held       <= '0;
    end else begin
      state_q    <= state_d;
      emit_q     <= emit_d;
      emit_entry <= {ext_c, is_make, rx_byte, ascii_of(ext_c, rx_byte)};
      if (is_break) begin
        last_valid <= 1'b0;
        held       <= held & ~key_mask(ext_c, rx_byte);
      end else if (is_make) begin
        last_valid <= 1'b1;
        last_key   <= {ext_c, rx_byte};
        held       <= held | key_mask(ext_c, rx_byte);
      end
    end
  end

  // Event FIFO, first-word-fall-through; a pop frees a slot for a same-cycle push
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, pop, wr_en;
  logic [17:0] head;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ev_valid = (wr_ptr != rd_ptr);
  assign pop      = ev_valid && ev_ready;
  assign wr_en    = emit_q && (!full || pop);

  always_ff @(posedge clk_100mhz) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= emit_entry;
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (emit_q && full && !pop) overflow <= 1'b1;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign ev_ext   = ev_valid & head[17];
  assign ev_press = ev_valid & head[16];
  assign ev_code  = ev_valid ? head[15:8] : 8'h00;
  assign ev_ascii = ev_valid ? head[7:0]  : 8'h00;

endmodule

// File: tb/tb_ps2_key_events.sv
// tb/tb_ps2_key_events.sv - directed self-checking bench for ps2_key_events.
module tb_ps2_key_events;
  logic       clk_100mhz = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b1;
  logic       ev_valid, ev_press, ev_ext, frame_err, overflow;
  logic [7:0] ev_code, ev_ascii, held;

  int errors = 0;
  int checks = 0;
  int ferr_cycles = 0;
  logic [17:0] evq [$];

  ps2_key_events #(.FIFO_DEPTH(8), .FILTER_LEN(8), .TIMEOUT_CYCLES(300)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_press(ev_press), .ev_ext(ev_ext),
    .ev_code(ev_code), .ev_ascii(ev_ascii), .held(held), .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Entries recorded as {ext, press, code, ascii}
  always @(negedge clk_100mhz) begin
    if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_press, ev_code, ev_ascii});
    if (frame_err) ferr_cycles++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(10);
    ps2_clk = 1'b0;
    cycles(20);
    ps2_clk = 1'b1;
    cycles(10);
  endtask

  task automatic send_raw(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    cycles(10);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_raw({1'b1, ~^d, d, 1'b0}, 11);
  endtask

  task automatic send_bad_parity(input logic [7:0] d);
    send_raw({1'b1, ^d, d, 1'b0}, 11);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycles(4);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    checks++; if (ev_press !== 1'b0) begin errors++; $display("FAIL reset_ev_press: got %b want 0", ev_press); end
    checks++; if (ev_ext !== 1'b0) begin errors++; $display("FAIL reset_ev_ext: got %b want 0", ev_ext); end
    checks++; if (ev_code !== 8'h00) begin errors++; $display("FAIL reset_ev_code: got %h want 00", ev_code); end
    checks++; if (ev_ascii !== 8'h00) begin errors++; $display("FAIL reset_ev_ascii: got %h want 00", ev_ascii); end
    checks++; if (held !== 8'h00) begin errors++; $display("FAIL reset_held: got %h want 00", held); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    cycles(4);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL post_reset_ev_valid: got %b want 0", ev_valid); end
  endtask

  task automatic test_make_break;
    logic [17:0] got;
    evq.delete();
    send_byte(8'h1C);
    checks++; if (held !== 8'h02) begin errors++; $display("FAIL mb_held_set: got %h want 02", held); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++; if (held !== 8'h00) begin errors++; $display("FAIL mb_held_clr: got %h want 00", held); end
    checks++; if (evq.size() !== 2) begin errors++; $display("FAIL mb_count: got %0d want 2", evq.size()); end
    else begin
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b1, 8'h1C, 8'h61}) begin errors++; $display("FAIL mb_make: got %h want %h", got, {1'b0, 1'b1, 8'h1C, 8'h61}); end
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b0, 8'h1C, 8'h61}) begin errors++; $display("FAIL mb_break: got %h want %h", got, {1'b0, 1'b0, 8'h1C, 8'h61}); end
    end
  endtask

  task automatic test_typematic;
    logic [17:0] got;
    evq.delete();
    repeat (3) send_byte(8'h1D);
    checks++; if (held !== 8'h01) begin errors++; $display("FAIL tm_held_set: got %h want 01", held); end
    send_byte(8'hF0);
    send_byte(8'h1D);
    checks++; if (held !== 8'h00) begin errors++; $display("FAIL tm_held_clr: got %h want 00", held); end
    checks++; if (evq.size() !== 2) begin errors++; $display("FAIL tm_count: got %0d want 2", evq.size()); end
    else begin
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b1, 8'h1D, 8'h77}) begin errors++; $display("FAIL tm_make: got %h want %h", got, {1'b0, 1'b1, 8'h1D, 8'h77}); end
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b0, 8'h1D, 8'h77}) begin errors++; $display("FAIL tm_break: got %h want %h", got, {1'b0, 1'b0, 8'h1D, 8'h77}); end
    end
  endtask

  task automatic test_extended;
    logic [17:0] got, exp_make, exp_brk;
    logic [7:0]  exp_held;
`ifdef PS2_EXTENDED_KEYS_EN
    exp_make = {1'b1, 1'b1, 8'h75, 8'h80};
    exp_brk  = {1'b1, 1'b0, 8'h75, 8'h80};
    exp_held = 8'h10;
`else
    exp_make = {1'b0, 1'b1, 8'h75, 8'h00};
    exp_brk  = {1'b0, 1'b0, 8'h75, 8'h00};
    exp_held = 8'h00;
`endif
    evq.delete();
    send_byte(8'hE0);
    send_byte(8'h75);
    checks++; if (held !== exp_held) begin errors++; $display("FAIL ext_held_set: got %h want %h", held, exp_held); end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    checks++; if (held !== 8'h00) begin errors++; $display("FAIL ext_held_clr: got %h want 00", held); end
    checks++; if (evq.size() !== 2) begin errors++; $display("FAIL ext_count: got %0d want 2", evq.size()); end
    else begin
      got = evq.pop_front();
      checks++; if (got !== exp_make) begin errors++; $display("FAIL ext_make: got %h want %h", got, exp_make); end
      got = evq.pop_front();
      checks++; if (got !== exp_brk) begin errors++; $display("FAIL ext_break: got %h want %h", got, exp_brk); end
    end
  endtask

  task automatic test_parity_error;
    logic [17:0] got;
    int f0;
    evq.delete();
    f0 = ferr_cycles;
    send_bad_parity(8'h16);
    checks++; if (ferr_cycles - f0 !== 1) begin errors++; $display("FAIL par_ferr_pulse: got %0d cycles want 1", ferr_cycles - f0); end
    checks++; if (evq.size() !== 0) begin errors++; $display("FAIL par_no_event: got %0d want 0", evq.size()); end
    send_byte(8'h16);
    send_byte(8'hF0);
    f0 = ferr_cycles;
    send_bad_parity(8'h16);
    checks++; if (ferr_cycles - f0 !== 1) begin errors++; $display("FAIL par_ferr_pulse2: got %0d cycles want 1", ferr_cycles - f0); end
    send_byte(8'h16);
    checks++; if (evq.size() !== 2) begin errors++; $display("FAIL par_count: got %0d want 2", evq.size()); end
    else begin
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b1, 8'h16, 8'h31}) begin errors++; $display("FAIL par_make: got %h want %h", got, {1'b0, 1'b1, 8'h16, 8'h31}); end
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b0, 8'h16, 8'h31}) begin errors++; $display("FAIL par_state_kept: got %h want %h", got, {1'b0, 1'b0, 8'h16, 8'h31}); end
    end
  endtask

  task automatic test_overflow;
    logic [7:0]  codes  [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    logic [7:0]  asciis [10] = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69, 8'h6F, 8'h70};
    logic [17:0] got;
    evq.delete();
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(codes[i]);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
    send_byte(codes[8]);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    send_byte(codes[9]);
    checks++; if (ev_valid !== 1'b1 || ev_code !== 8'h15) begin errors++; $display("FAIL ovf_head_hold: got valid=%b code=%h want 1/15", ev_valid, ev_code); end
    checks++; if (held !== 8'h01) begin errors++; $display("FAIL ovf_held: got %h want 01", held); end
    ev_ready = 1'b1;
    cycles(20);
    checks++; if (evq.size() !== 8) begin errors++; $display("FAIL ovf_drain_count: got %0d want 8", evq.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        got = evq.pop_front();
        checks++; if (got !== {1'b0, 1'b1, codes[i], asciis[i]}) begin errors++; $display("FAIL ovf_order_%0d: got %h want %h", i, got, {1'b0, 1'b1, codes[i], asciis[i]}); end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_reset_midframe;
    logic [17:0] got;
    evq.delete();
    send_raw(11'h016, 4);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(3);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf_clr: got %b want 0", overflow); end
    checks++; if (held !== 8'h00) begin errors++; $display("FAIL rst_held_clr: got %h want 00", held); end
    send_byte(8'h4D);
    checks++; if (evq.size() !== 1) begin errors++; $display("FAIL rst_count: got %0d want 1", evq.size()); end
    else begin
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b1, 8'h4D, 8'h70}) begin errors++; $display("FAIL rst_fresh_make: got %h want %h", got, {1'b0, 1'b1, 8'h4D, 8'h70}); end
    end
  endtask

  task automatic test_timeout;
    logic [17:0] got;
    int f0;
    evq.delete();
    f0 = ferr_cycles;
    send_raw(11'h01A, 5);
    cycles(400);
    send_byte(8'h29);
    checks++; if (ferr_cycles !== f0) begin errors++; $display("FAIL to_no_ferr: got %0d cycles want 0", ferr_cycles - f0); end
    checks++; if (evq.size() !== 1) begin errors++; $display("FAIL to_count: got %0d want 1", evq.size()); end
    else begin
      got = evq.pop_front();
      checks++; if (got !== {1'b0, 1'b1, 8'h29, 8'h20}) begin errors++; $display("FAIL to_event: got %h want %h", got, {1'b0, 1'b1, 8'h29, 8'h20}); end
    end
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_typematic;
    test_extended;
    test_parity_error;
    test_overflow;
    test_reset_midframe;
    test_timeout;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
